// File: rtl/csr_apb_pkg.sv
// Shared definitions for the CSR APB requester: register map, FSM encoding,
// legal control opcodes and small arithmetic helpers.
package csr_apb_pkg;

  // CSR register map as seen on the APB slave port
  localparam int unsigned REG_NUMBER = 5;
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_0      = 1;
  localparam int unsigned REG_1      = 2;
  localparam int unsigned REG_RES    = 3;
  localparam int unsigned REG_STATUS = 4;

  // APB requester phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Opcodes the CSR block accepts in REG_CTRL bits [1:0]
  localparam logic [1:0] CTRL_OP_1 = 2'b01;
  localparam logic [1:0] CTRL_OP_2 = 2'b10;

  // True when a ctrl_op field holds one of the accepted opcodes
  function automatic logic is_legal_ctrl_op(input logic [1:0] op);
    return (op == CTRL_OP_1) || (op == CTRL_OP_2);
  endfunction

  // 8-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase. Cleared when a transfer
// starts, counts pready-low cycles, saturates at 255 and flags expiry once
// the count reaches TIMEOUT_CYCLES-1.
module apb_wait_timer
  import csr_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear has priority over counting
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = sat_inc8(count_q);
    end else begin
      count_d = count_q;
    end
  end

  d_ff_async_en #(.WIDTH(8), .RESET_VAL(8'd0)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .en  (clr_i | en_i),
    .d   (count_d),
    .q   (count_q)
  );

  assign expired_o = (count_q >= LIMIT);

endmodule

// File: rtl/d_ff_async_en.sv
// Generic register with asynchronous active-high reset and load enable.
module d_ff_async_en #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset forces the reset value immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/apb_csr_master.sv
// APB requester for the CSR register file. Takes one read/write command at a
// time over valid/ready, runs SETUP then ACCESS, and returns a one-cycle
// response carrying read data, slave error and timeout status.
module apb_csr_master
  import csr_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam int unsigned CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned RSP_W = 2 + DATA_WIDTH;

  apb_state_e state_q;
  apb_state_e state_d;
  logic [1:0] state_raw_q;

  logic       accept_s;
  logic       done_s;
  logic       abort_s;
  logic       expired_s;

  // cmd_ready, busy, penable, psel
  logic [3:0] ctrl_d;
  logic [3:0] ctrl_q;

  logic [CMD_W-1:0] cmd_q;

  logic                  rsp_valid_q;
  logic [RSP_W-1:0]      rsp_d;
  logic [RSP_W-1:0]      rsp_q;
  logic                  rsp_err_d;
  logic                  rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  assign state_q = apb_state_e'(state_raw_q);

  // Next-state decode; completion wins over timeout in the same cycle
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    done_s   = 1'b0;
    abort_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else if (expired_s) begin
          abort_s = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus/handshake outputs are registered from the next state
  always_comb begin
    ctrl_d    = 4'b1000;
    ctrl_d[0] = (state_d != IDLE);
    ctrl_d[1] = (state_d == ACCESS);
    ctrl_d[2] = (state_d != IDLE);
    ctrl_d[3] = (state_d == IDLE);
  end

  // Response payload: read data only for a clean read, error on slave error or abort
  always_comb begin
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = {DATA_WIDTH{1'b0}};
    if (done_s) begin
      rsp_err_d = pslverr;
      if (!pwrite && !pslverr) begin
        rsp_rdata_d = prdata;
      end else begin
        rsp_rdata_d = {DATA_WIDTH{1'b0}};
      end
    end else if (abort_s) begin
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end else begin
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
    end
    rsp_d = {rsp_timeout_d, rsp_err_d, rsp_rdata_d};
  end

  d_ff_async_en #(.WIDTH(2), .RESET_VAL(2'd0)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_raw_q)
  );

  d_ff_async_en #(.WIDTH(4), .RESET_VAL(4'b1000)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  d_ff_async_en #(.WIDTH(CMD_W), .RESET_VAL({CMD_W{1'b0}})) u_cmd_reg (
    .clk (clk),
    .rst (rst),
    .en  (accept_s),
    .d   ({cmd_write, cmd_addr, cmd_wdata}),
    .q   (cmd_q)
  );

  d_ff_async_en #(.WIDTH(1), .RESET_VAL(1'b0)) u_rsp_valid_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (done_s | abort_s),
    .q   (rsp_valid_q)
  );

  d_ff_async_en #(.WIDTH(RSP_W), .RESET_VAL({RSP_W{1'b0}})) u_rsp_reg (
    .clk (clk),
    .rst (rst),
    .en  (done_s | abort_s),
    .d   (rsp_d),
    .q   (rsp_q)
  );

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept_s),
    .en_i      ((state_q == ACCESS) && !pready),
    .expired_o (expired_s)
  );

  assign psel      = ctrl_q[0];
  assign penable   = ctrl_q[1];
  assign busy      = ctrl_q[2];
  assign cmd_ready = ctrl_q[3];

  assign {pwrite, paddr, pwdata} = cmd_q;

  assign rsp_valid                        = rsp_valid_q;
  assign {rsp_timeout, rsp_err, rsp_rdata} = rsp_q;

endmodule

// File: tb/tb_apb_csr_master.sv
// Directed bench for apb_csr_master: a transaction-level model predicts the
// busy window and response of each command from the wait-state count the
// simulated slave will insert, and a per-cycle monitor checks the DUT.
module tb_apb_csr_master;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_csr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .rsp_timeout (rsp_timeout), .busy (busy),
    .psel (psel), .penable (penable), .pwrite (pwrite), .paddr (paddr),
    .pwdata (pwdata), .pready (pready), .prdata (prdata), .pslverr (pslverr)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;   // pready-low cycles the slave inserts; >= T means never ready
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  txn_t pend_q[$];
  txn_t cur;
  bit   m_active = 1'b0;
  int   m_s   = 0;      // first SETUP cycle
  int   m_rsp = 0;      // cycle in which rsp_valid is due
  int   acc_cnt = 0;
  int   last_acc_edge = 0;

  int            s_waits = 0;
  logic [DW-1:0] s_rdata = '0;
  logic          s_err   = 1'b0;
  int            acc_k   = 0;

  int            rsp_cyc_q[$];
  logic [DW-1:0] rsp_rd_q[$];
  logic          rsp_err_q[$];
  logic          rsp_to_q[$];

  bit            e_busy, e_en, e_rsp, e_to, e_err;
  logic [DW-1:0] e_rd;

  assign prdata  = s_rdata;
  assign pslverr = s_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: a command is taken at an edge when the previous cycle was idle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 1'b0;
    end else if ((!m_active || (cyc - 1 >= m_rsp)) && cmd_valid && pend_q.size() > 0) begin
      cur      = pend_q.pop_front();
      m_active = 1'b1;
      m_s      = cyc;
      m_rsp    = (cur.waits < T) ? (m_s + 2 + cur.waits) : (m_s + 1 + T);
      s_waits  = cur.waits;
      s_rdata  = cur.rdata;
      s_err    = cur.err;
      last_acc_edge = cyc - 1;
      acc_cnt++;
    end
  end

  // Slave: raise pready in the ACCESS cycle whose index equals the wait count
  always @(posedge clk) begin
    #1;
    if (psel && penable) begin
      pready = (acc_k == s_waits);
      acc_k++;
    end else begin
      pready = 1'b0;
      acc_k  = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      e_busy = m_active && (cyc >= m_s) && (cyc < m_rsp);
      e_en   = m_active && (cyc >= m_s + 1) && (cyc < m_rsp);
      e_rsp  = m_active && (cyc == m_rsp);
      chk("psel", psel, e_busy);
      chk("penable", penable, e_en);
      chk("busy", busy, e_busy);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("rsp_valid", rsp_valid, e_rsp);
      if (e_busy) begin
        chk("paddr", paddr, cur.addr);
        chk("pwrite", pwrite, cur.wr);
        chk("pwdata", pwdata, cur.wdata);
      end
      if (e_rsp) begin
        e_to  = (cur.waits >= T);
        e_err = e_to || cur.err;
        e_rd  = (!cur.wr && !e_err) ? cur.rdata : 32'h0;
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, e_to);
        chk("rsp_rdata", rsp_rdata, e_rd);
      end
      if (rsp_valid) begin
        rsp_cyc_q.push_back(cyc);
        rsp_rd_q.push_back(rsp_rdata);
        rsp_err_q.push_back(rsp_err);
        rsp_to_q.push_back(rsp_timeout);
      end
    end
  end

  task automatic issue(input txn_t t);
    int a0;
    int n;
    pend_q.push_back(t);
    @(negedge clk);
    cmd_write = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_valid = 1'b1;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt == a0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (acc_cnt == a0) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: command not taken within %0d cycles", n);
    end
  endtask

  task automatic wait_rsp(input int idx, output int rc);
    int n;
    n = 0;
    while (rsp_cyc_q.size() <= idx && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cyc_q.size() <= idx) begin
      tests++;
      fails++;
      $display("FAIL rsp_wait: no response within %0d cycles", n);
      rc = -1;
    end else begin
      rc = rsp_cyc_q[idx];
    end
  endtask

  // Single command with hand-computed edge-to-response latency
  task automatic single(input txn_t t, input int exp_lat, input string name, output int idx);
    int acc_e;
    int rc;
    idx = rsp_cyc_q.size();
    issue(t);
    acc_e = last_acc_edge;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(idx, rc);
    chk({name, "_latency"}, rc - acc_e, exp_lat);
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int w, input logic [DW-1:0] rd, input logic er);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.waits = w; t.rdata = rd; t.err = er;
    return t;
  endfunction

  initial begin
    int idx;
    int idx2;
    int rc1;
    int rc2;
    int n0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_paddr", paddr, 3'd0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Write REG_CTRL, zero wait states
    single(mk(1'b1, 3'd0, 32'h1, 0, 32'hDEAD_BEEF, 1'b0), 3, "wr_ctrl", idx);
    chk("wr_ctrl_err_lit", rsp_err_q[idx], 1'b0);
    chk("wr_ctrl_rdata_lit", rsp_rd_q[idx], 32'h0);

    // Read REG_RES with one wait state
    single(mk(1'b0, 3'd3, 32'h0, 1, 32'h0ABC_DEF, 1'b0), 4, "rd_res", idx);
    chk("rd_res_rdata_lit", rsp_rd_q[idx], 32'h0ABC_DEF);
    chk("rd_res_err_lit", rsp_err_q[idx], 1'b0);

    // Write REG_STATUS, slave error
    single(mk(1'b1, 3'd4, 32'h12, 0, 32'h5555_5555, 1'b1), 3, "wr_status_err", idx);
    chk("wr_status_err_lit", rsp_err_q[idx], 1'b1);
    chk("wr_status_to_lit", rsp_to_q[idx], 1'b0);

    // Hung slave: abort after T ACCESS cycles
    single(mk(1'b0, 3'd1, 32'h0, 255, 32'hBAD0_BAD0, 1'b0), T + 2, "timeout", idx);
    chk("timeout_err_lit", rsp_err_q[idx], 1'b1);
    chk("timeout_to_lit", rsp_to_q[idx], 1'b1);
    chk("timeout_rdata_lit", rsp_rd_q[idx], 32'h0);

    // Slave ready in the last ACCESS cycle before expiry: no timeout
    single(mk(1'b0, 3'd2, 32'h0, T - 1, 32'h1357_9BDF, 1'b0), T + 2, "late_ready", idx);
    chk("late_ready_to_lit", rsp_to_q[idx], 1'b0);
    chk("late_ready_rdata_lit", rsp_rd_q[idx], 32'h1357_9BDF);

    // Illegal address with slave error and two wait states
    single(mk(1'b0, 3'd6, 32'h0, 2, 32'h7777_7777, 1'b1), 5, "illegal_addr", idx);

    // Back-to-back with cmd_valid held
    idx = rsp_cyc_q.size();
    issue(mk(1'b1, 3'd1, 32'h5, 0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'd4, 32'h0, 0, 32'h3, 1'b0));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(idx, rc1);
    wait_rsp(idx + 1, rc2);
    chk("b2b_gap", rc2 - rc1, 3);
    if (rsp_rd_q.size() > idx + 1) begin
      chk("b2b_rdata_lit", rsp_rd_q[idx + 1], 32'h3);
    end else begin
      chk("b2b_rdata_missing", rsp_rd_q.size(), idx + 2);
    end

    // Reset during ACCESS
    n0 = rsp_cyc_q.size();
    issue(mk(1'b1, 3'd2, 32'hCAFE, 255, 32'h0, 1'b0));
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_penable", penable, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_psel", psel, 1'b0);
    chk("async_rst_penable", penable, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cyc_q.size(), n0);
    single(mk(1'b1, 3'd1, 32'hA5A5_0001, 0, 32'h0, 1'b0), 3, "after_rst", idx2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_csr_master.md
Name: apb_csr_master

Overview:
- APB requester that drives the CSR register file's APB slave port (REG_CTRL=0, REG_0=1, REG_1=2, REG_RES=3, REG_STATUS=4).
- Accepts single read/write commands over a valid/ready handshake.
- Sequences the APB SETUP and ACCESS phases, waits for pready and returns prdata and pslverr as a one-cycle response.
- Sits between the test/host sequencer and the CSR block; guards against a hung slave with a wait-state timeout.

Parameters:
- ADDR_WIDTH, 3, APB address width; equals clog2 of REG_NUMBER (5).
- DATA_WIDTH, 32, pwdata/prdata width (APB bus size).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target register address.
- cmd_wdata  in  DATA_WIDTH  write data; bits [1:0] carry ctrl_op for REG_CTRL.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- busy  out  1  transaction in flight (state != IDLE).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset state (async, immediate):
  - state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout and busy are 0.
  - paddr, pwdata and rsp_rdata are 0.
  - cmd_ready=1 after reset release.
- Reset mid-transfer: the transfer is dropped, no response is produced, and psel falls asynchronously.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0; always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1; the wait counter increments each cycle pready=0.
    - pready=1: capture pslverr and, for reads with pslverr=0, capture prdata. Go to IDLE.
    - Counter reaches TIMEOUT_CYCLES-1 with pready=0: abort and go to IDLE with timeout response.
- Response:
  - rsp_valid pulses for exactly one cycle, in the cycle after completion, coincident with IDLE/cmd_ready=1.
  - rsp_err = pslverr | timeout.
  - rsp_rdata = 0 unless the transfer was a successful read.
  - rsp_rdata and rsp_err hold their values until the next response.
- Latency: command accepted at edge N → SETUP in cycle N+1, ACCESS in N+2 → with zero wait states rsp_valid in N+3. Each pready-low cycle adds one. Minimum 3 cycles per transfer.
- Back-to-back: a command may be accepted in the same cycle rsp_valid is high; no idle cycle is required.
- psel/penable drop to 0 in the cycle after completion or abort. paddr/pwdata/pwrite keep their last values in IDLE (stable across SETUP→ACCESS by construction).
- The wait counter is 8 bits, cleared on entry to SETUP, and saturates; it does not wrap.
- cmd_* inputs are ignored while busy.
- No address range check: illegal addresses (5..7) are issued and the slave's pslverr is reported.
- The CSR slave inserts one wait state on REG_RES reads; this block must tolerate any number below the timeout.

Decomposition:
- Shared package csr_apb_pkg:
  - REG_NUMBER, REG_CTRL, REG_0, REG_1, REG_RES, REG_STATUS.
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
  - Legal ctrl_op values 2'b01 and 2'b10.
- One sub-module, apb_wait_timer: clear/enable saturating counter with expired flag compared against TIMEOUT_CYCLES-1.
- State and output registers reuse d_ff_async_en.

Test Plan:
- Write REG_CTRL (addr 0, wdata 0x1), slave pready=1 in first ACCESS → psel high in cycles N+1..N+2, penable only in N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read REG_RES (addr 3), slave pready after one wait state, prdata=0x0ABCDEF → rsp_valid at N+4, rsp_rdata=0x0ABCDEF, rsp_err=0.
- Write REG_STATUS (addr 4), slave pslverr=1 with pready → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- pready held 0 with TIMEOUT_CYCLES=16 → abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; psel=0 the next cycle.
- Two commands with cmd_valid held continuously (write REG_0=5, then read REG_STATUS) → second SETUP begins the cycle after the first rsp_valid; no gap cycle; both responses correct.
- Assert rst during ACCESS → psel/penable/busy go to 0 immediately, no rsp_valid; first command after release completes normally.
